// File: rtl/fft_bin_gate.sv
// ============================================================================
// fft_bin_gate -- aligns FFT bin beats into frames and forwards bins BIN_LO..BIN_HI
// through a first-word-fall-through FIFO. Optional macro: FFT_BIN_GATE_MAG_THRESHOLD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_bin_gate #(
   parameter int FFT_SIZE   = 1024,
   parameter int BIN_LO     = 4,
   parameter int BIN_HI     = 128,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [127:0]                fft_data_in,
   input  logic                        fft_valid_in,
   input  logic                        fft_last_in,
   output logic                        fft_ready_out,
   input  logic [16:0]                 mag_threshold,
   output logic [127:0]                bin_data_out,
   output logic [$clog2(FFT_SIZE)-1:0] bin_index_out,
   output logic                        bin_valid_out,
   input  logic                        bin_ready_in,
   output logic                        frame_done_out,
   output logic [15:0]                 drop_count_out
);

   localparam int IDX_W = $clog2(FFT_SIZE);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = IDX_W + 128;

   typedef enum logic [0:0] {
      ALIGN = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   bin_cnt;
   logic               frame_done;
   logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   fifo_cnt;

   logic accept;
   logic pop;
   logic push;
   logic in_range;
   logic at_end;
   logic mag_pass;

   assign fft_ready_out  = fifo_cnt < CNT_W'(FIFO_DEPTH);
   assign bin_valid_out  = fifo_cnt != '0;
   assign frame_done_out = frame_done;

   // Outputs read as zero while the FIFO is empty so the storage needs no reset.
   assign bin_data_out  = bin_valid_out ? fifo_mem[rd_ptr][127:0] : '0;
   assign bin_index_out = bin_valid_out ? fifo_mem[rd_ptr][ENT_W-1 -: IDX_W] : '0;

`ifdef FFT_BIN_GATE_MAG_THRESHOLD_EN
   logic [16:0] re_ext;
   logic [16:0] im_ext;
   logic [16:0] re_abs;
   logic [16:0] im_abs;
   logic [16:0] mag;
   logic [15:0] drop_cnt;

   // 17-bit absolute values so that |-32768| is representable.
   assign re_ext   = {fft_data_in[15], fft_data_in[15:0]};
   assign im_ext   = {fft_data_in[31], fft_data_in[31:16]};
   assign re_abs   = re_ext[16] ? (~re_ext + 17'd1) : re_ext;
   assign im_abs   = im_ext[16] ? (~im_ext + 17'd1) : im_ext;
   assign mag      = re_abs + im_abs;
   assign mag_pass = mag >= mag_threshold;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_cnt <= '0;
      end else if (accept && (state == RUN) && in_range && !mag_pass
                   && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign drop_count_out = drop_cnt;
`else
   logic unused_thr;

   assign unused_thr     = ^mag_threshold;
   assign mag_pass       = 1'b1;
   assign drop_count_out = '0;
`endif

   always_comb begin
      accept   = fft_valid_in && fft_ready_out;
      pop      = bin_valid_out && bin_ready_in;
      in_range = (bin_cnt >= IDX_W'(BIN_LO)) && (bin_cnt <= IDX_W'(BIN_HI));
      at_end   = bin_cnt == IDX_W'(FFT_SIZE - 1);
      push     = accept && (state == RUN) && in_range && mag_pass;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= ALIGN;
         bin_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            if (state == ALIGN) begin
               if (fft_last_in) begin
                  state   <= RUN;
                  bin_cnt <= '0;
               end
            end else if (fft_last_in) begin
               // A last beat anywhere but the final bin means we lost alignment.
               bin_cnt <= '0;
               if (at_end) begin
                  frame_done <= 1'b1;
               end else begin
                  state <= ALIGN;
               end
            end else if (at_end) begin
               bin_cnt <= '0;
               state   <= ALIGN;
            end else begin
               bin_cnt <= bin_cnt + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {bin_cnt, fft_data_in};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft_bin_gate.sv
// ============================================================================
// tb_fft_bin_gate -- vector table, directed frame sequences and random traffic
// compared every cycle against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fft_bin_gate;

   localparam int FFT_SIZE   = 1024;
   localparam int BIN_LO     = 4;
   localparam int BIN_HI     = 128;
   localparam int DEPTH      = 8;
   localparam int IDX_W      = $clog2(FFT_SIZE);

   logic                clk_in = 1'b0;
   logic                rst_in = 1'b1;
   logic [127:0]        fft_data_in = '0;
   logic                fft_valid_in = 1'b0;
   logic                fft_last_in = 1'b0;
   logic                fft_ready_out;
   logic [16:0]         mag_threshold = '0;
   logic [127:0]        bin_data_out;
   logic [IDX_W-1:0]    bin_index_out;
   logic                bin_valid_out;
   logic                bin_ready_in = 1'b0;
   logic                frame_done_out;
   logic [15:0]         drop_count_out;

   fft_bin_gate #(
      .FFT_SIZE  (FFT_SIZE),
      .BIN_LO    (BIN_LO),
      .BIN_HI    (BIN_HI),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .fft_data_in   (fft_data_in),
      .fft_valid_in  (fft_valid_in),
      .fft_last_in   (fft_last_in),
      .fft_ready_out (fft_ready_out),
      .mag_threshold (mag_threshold),
      .bin_data_out  (bin_data_out),
      .bin_index_out (bin_index_out),
      .bin_valid_out (bin_valid_out),
      .bin_ready_in  (bin_ready_in),
      .frame_done_out(frame_done_out),
      .drop_count_out(drop_count_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int           idx;
      logic [127:0] data;
   } item_t;

   typedef struct {
      bit rst, vin, last, rdy;
      bit e_ready, e_valid, e_fd, chk_zero;
   } vec_t;

   item_t q[$];
   int    popped[$];
   bit    m_run;
   int    m_cnt;
   int    m_drop;
   bit    exp_fd;
   bit    last_acc;
   int    fd_seen;
   int    vecs;
   int    errs;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int abs16(input logic [15:0] v);
      int s;
      s = int'($signed(v));
      return (s < 0) ? -s : s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: compare outputs against the model, then advance the model with the
   // inputs that the coming edge will sample.
   task automatic step();
      int    sz;
      bit    acc, pop, fd_n, keep;
      int    idx, mag;
      item_t it;
      @(negedge clk_in);
      sz = q.size();
      chk("ready", fft_ready_out, sz < DEPTH);
      chk("valid", bin_valid_out, sz > 0);
      if (sz > 0) begin
         chk("data", bin_data_out, q[0].data);
         chk("index", bin_index_out, q[0].idx);
      end
      chk("frame_done", frame_done_out, exp_fd);
      chk("drop_count", drop_count_out, m_drop);
      if (frame_done_out) fd_seen++;
      acc      = fft_valid_in && (sz < DEPTH);
      pop      = (sz > 0) && bin_ready_in;
      fd_n     = 1'b0;
      last_acc = 1'b0;
      if (rst_in) begin
         q.delete();
         m_run  = 1'b0;
         m_cnt  = 0;
         m_drop = 0;
      end else begin
         last_acc = acc;
         if (pop) begin
            it = q.pop_front();
            popped.push_back(it.idx);
         end
         if (acc && !m_run) begin
            if (fft_last_in) begin
               m_run = 1'b1;
               m_cnt = 0;
            end
         end else if (acc) begin
            idx  = m_cnt;
            keep = (idx >= BIN_LO) && (idx <= BIN_HI);
`ifdef FFT_BIN_GATE_MAG_THRESHOLD_EN
            mag = abs16(fft_data_in[15:0]) + abs16(fft_data_in[31:16]);
            if (keep && (mag < int'(mag_threshold))) begin
               keep = 1'b0;
               if (m_drop < 65535) m_drop++;
            end
`else
            mag = 0;
`endif
            if (keep) begin
               it.idx  = idx;
               it.data = fft_data_in;
               q.push_back(it);
            end
            if (fft_last_in) begin
               m_cnt = 0;
               if (idx == FFT_SIZE - 1) fd_n = 1'b1;
               else m_run = 1'b0;
            end else if (idx == FFT_SIZE - 1) begin
               m_cnt = 0;
               m_run = 1'b0;
            end else begin
               m_cnt++;
            end
         end
      end
      @(posedge clk_in);
      #1;
      exp_fd = fd_n;
   endtask

   task automatic send(input logic [127:0] data, input bit last);
      int n;
      fft_valid_in = 1'b1;
      fft_data_in  = data;
      fft_last_in  = last;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_acc && n < 200);
      if (!last_acc) begin
         vecs++;
         errs++;
         $display("FAIL accept_timeout: beat not accepted after %0d cycles", n);
      end
      fft_valid_in = 1'b0;
      fft_last_in  = 1'b0;
   endtask

   task automatic idle(input int n);
      fft_valid_in = 1'b0;
      fft_last_in  = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_reset();
      fft_valid_in = 1'b0;
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      popped.delete();
      fd_seen = 0;
   endtask

   task automatic send_frame(input int n, input int last_at);
      for (int i = 0; i < n; i++) send(rnd128(), i == last_at);
   endtask

   task automatic frame_checks(input string name, input int exp_n, input int exp_fds);
      chk({name, "_pops"}, popped.size(), exp_n);
      chk({name, "_frame_done"}, fd_seen, exp_fds);
      if (exp_n > 0 && popped.size() == exp_n) begin
         chk({name, "_first_idx"}, popped[0], BIN_LO);
         chk({name, "_last_idx"}, popped[exp_n-1], BIN_HI);
      end
   endtask

   vec_t tbl[11];

   initial begin
      logic [127:0] d;
      vecs = 0; errs = 0; fd_seen = 0;
      m_run = 0; m_cnt = 0; m_drop = 0; exp_fd = 0; last_acc = 0;

      tbl[0]  = '{1,0,0,0, 1,0,0,1};
      tbl[1]  = '{1,1,1,1, 1,0,0,1};
      tbl[2]  = '{0,1,0,0, 1,0,0,0};
      tbl[3]  = '{0,1,0,0, 1,0,0,0};
      tbl[4]  = '{0,1,1,0, 1,0,0,0};
      tbl[5]  = '{0,1,0,0, 1,0,0,0};
      tbl[6]  = '{0,1,0,0, 1,0,0,0};
      tbl[7]  = '{0,1,0,0, 1,0,0,0};
      tbl[8]  = '{0,1,0,0, 1,0,0,0};
      tbl[9]  = '{0,1,0,0, 1,1,0,0};
      tbl[10] = '{0,0,0,1, 1,0,0,0};

      repeat (2) @(posedge clk_in);
      #1;
      for (int i = 0; i < 11; i++) begin
         rst_in       = tbl[i].rst;
         fft_valid_in = tbl[i].vin;
         fft_last_in  = tbl[i].last;
         bin_ready_in = tbl[i].rdy;
         fft_data_in  = rnd128();
         step();
         chk("tbl_ready", fft_ready_out, tbl[i].e_ready);
         chk("tbl_valid", bin_valid_out, tbl[i].e_valid);
         chk("tbl_frame_done", frame_done_out, tbl[i].e_fd);
         if (tbl[i].chk_zero) begin
            chk("tbl_rst_data", bin_data_out, 128'd0);
            chk("tbl_rst_index", bin_index_out, 0);
            chk("tbl_rst_drop", drop_count_out, 0);
         end
      end

      // Full aligned frame, downstream always ready.
      do_reset();
      bin_ready_in = 1'b1;
      send(rnd128(), 1'b1);
      send_frame(FFT_SIZE, FFT_SIZE - 1);
      idle(20);
      frame_checks("full_frame", BIN_HI - BIN_LO + 1, 1);

      // Downstream stalled: FIFO fills, upstream is back-pressured, then drains.
      do_reset();
      bin_ready_in = 1'b0;
      send(rnd128(), 1'b1);
      send_frame(BIN_LO + DEPTH, -1);
      fft_valid_in = 1'b1;
      fft_data_in  = rnd128();
      repeat (5) step();
      chk("stall_ready_low", fft_ready_out, 1'b0);
      chk("stall_valid_high", bin_valid_out, 1'b1);
      chk("stall_head_index", bin_index_out, BIN_LO);
      bin_ready_in = 1'b1;
      for (int i = BIN_LO + DEPTH; i < FFT_SIZE; i++) send(rnd128(), i == FFT_SIZE - 1);
      idle(20);
      frame_checks("stalled_frame", BIN_HI - BIN_LO + 1, 1);

      // Early last at index 500, then realign and run a good frame.
      do_reset();
      bin_ready_in = 1'b1;
      send(rnd128(), 1'b1);
      send_frame(501, 500);
      idle(10);
      frame_checks("early_last", BIN_HI - BIN_LO + 1, 0);
      send_frame(30, -1);
      idle(5);
      chk("misaligned_discard", popped.size(), BIN_HI - BIN_LO + 1);
      popped.delete();
      fd_seen = 0;
      send(rnd128(), 1'b1);
      send_frame(FFT_SIZE, FFT_SIZE - 1);
      idle(20);
      frame_checks("realigned", BIN_HI - BIN_LO + 1, 1);

      // Reset with five beats buffered.
      do_reset();
      bin_ready_in = 1'b0;
      send(rnd128(), 1'b1);
      send_frame(BIN_LO + 5, -1);
      idle(1);
      chk("pre_rst_valid", bin_valid_out, 1'b1);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      chk("post_rst_valid", bin_valid_out, 1'b0);
      chk("post_rst_ready", fft_ready_out, 1'b1);
      bin_ready_in = 1'b1;
      popped.delete();
      send_frame(20, -1);
      idle(3);
      chk("post_rst_discard", popped.size(), 0);
      send(rnd128(), 1'b1);
      send_frame(10, -1);
      idle(5);
      chk("post_rst_resume", popped.size(), 10 - BIN_LO);

`ifdef FFT_BIN_GATE_MAG_THRESHOLD_EN
      do_reset();
      bin_ready_in  = 1'b1;
      mag_threshold = 17'd100;
      send(rnd128(), 1'b1);
      for (int i = 0; i <= 20; i++) begin
         d = rnd128();
         if (i == 10)      d[31:0] = {16'd30, 16'hFFC4};
         else if (i == 11) d[31:0] = {16'd0, 16'h8000};
         else              d[31:0] = {16'd0, 16'd1000};
         send(d, 1'b0);
      end
      idle(10);
      chk("mag_drop_count", drop_count_out, 16'd1);
      chk("mag_pops", popped.size(), 20 - BIN_LO);
      if (popped.size() > 6) chk("mag_bin11_kept", popped[6], 11);
      mag_threshold = '0;
`endif

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         fft_valid_in = ($urandom % 4) != 0;
         fft_last_in  = ($urandom % 200) == 0;
         bin_ready_in = ($urandom % 10) < 7;
         fft_data_in  = rnd128();
         rst_in       = ($urandom % 1500) == 0;
`ifdef FFT_BIN_GATE_MAG_THRESHOLD_EN
         mag_threshold = 17'($urandom % 3000);
`endif
         step();
      end
      rst_in = 1'b0;
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", errs);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/fft_bin_gate.md
FFT_BIN_GATE -- requirements
Module: fft_bin_gate

Interface
REQ-001 Parameter FFT_SIZE, 1024: bins per FFT frame; power of two.
REQ-002 Parameter BIN_LO, 4: lowest forwarded bin index, inclusive.
REQ-003 Parameter BIN_HI, 128: highest forwarded bin index, inclusive; BIN_LO <= BIN_HI < FFT_SIZE.
REQ-004 Parameter FIFO_DEPTH, 8: output buffer entries; power of two, >= 2.
REQ-005 The block SHALL have one clock, clk_in; reset is synchronous and active-high on rst_in.
REQ-006 clk_in  input  1  system clock.
REQ-007 rst_in  input  1  synchronous active-high reset.
REQ-008 fft_data_in  input  128  four mics, 32 bits each, mic0 in [31:0]; per mic IM [31:16], RE [15:0], signed.
REQ-009 fft_valid_in  input  1  upstream FFT beat valid.
REQ-010 fft_last_in  input  1  last bin of the frame.
REQ-011 fft_ready_out  output  1  block accepts a beat this cycle.
REQ-012 mag_threshold  input  17  unsigned minimum mic0 magnitude; ignored unless the macro is defined.
REQ-013 bin_data_out  output  128  forwarded beat, same format as fft_data_in; feeds the localizer.
REQ-014 bin_index_out  output  log2(FFT_SIZE)  bin index of bin_data_out.
REQ-015 bin_valid_out  output  1  output beat valid.
REQ-016 bin_ready_in  input  1  downstream (localizer ready) accepts output beat.
REQ-017 frame_done_out  output  1  one-cycle pulse per completed aligned frame.
REQ-018 drop_count_out  output  16  saturating count of in-range bins rejected by threshold.

Function
REQ-019 A beat is accepted when fft_valid_in and fft_ready_out are both high; a beat is popped when bin_valid_out and bin_ready_in are both high.
REQ-020 fft_ready_out SHALL be high when FIFO occupancy < FIFO_DEPTH, independent of fft_valid_in; simultaneous pop does not raise it in the same cycle.
REQ-021 States: ALIGN and RUN; in ALIGN accepted beats are discarded; an accepted beat with fft_last_in moves to RUN with bin counter 0.
REQ-022 In RUN each accepted beat takes the current bin counter as its index; counter increments after it, wrapping FFT_SIZE-1 -> 0.
REQ-023 An accepted beat with fft_last_in in RUN resets the counter to 0; if its index != FFT_SIZE-1 the state returns to ALIGN and no frame_done_out pulse occurs.
REQ-024 An accepted beat at index FFT_SIZE-1 without fft_last_in SHALL be processed normally, then the state returns to ALIGN.
REQ-025 An accepted RUN beat with BIN_LO <= index <= BIN_HI (and passing REQ-034 when enabled) SHALL be pushed as {index, data}; all others are discarded.
REQ-026 FIFO is first-word-fall-through: a beat pushed into an empty FIFO at cycle N is on the outputs with bin_valid_out high at cycle N+1.
REQ-027 Push and pop in the same cycle SHALL leave occupancy unchanged; output data SHALL hold stable while bin_valid_out is high and bin_ready_in low.
REQ-028 frame_done_out SHALL pulse for one cycle the cycle after accepting a correctly aligned last beat (index FFT_SIZE-1 with fft_last_in).
REQ-029 Pointers wrap modulo FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH and no beat is lost or duplicated.

Reset
REQ-030 While rst_in is high at a clk_in edge: state ALIGN, counter 0, FIFO emptied, drop_count_out 0.
REQ-031 Output reset values: bin_valid_out 0, frame_done_out 0, fft_ready_out 1 after reset, bin_data_out 0, bin_index_out 0, drop_count_out 0.
REQ-032 Reset mid-frame SHALL discard buffered beats; forwarding resumes only after the next last beat is seen.

Configuration
REQ-033 Macro FFT_BIN_GATE_MAG_THRESHOLD_EN selects magnitude gating.
REQ-034 Defined: mic0 magnitude |RE|+|IM| computed unsigned 17-bit (|-32768| = 32768); in-range beats with magnitude < mag_threshold are discarded and increment drop_count_out, saturating at 0xFFFF.
REQ-035 Undefined: all in-range RUN beats are forwarded; mag_threshold ignored; drop_count_out constant 0.

Verification
REQ-036 Reset, one junk beat, then 1024-beat frame with last on beat 1023, bin_ready_in high -> 125 beats out, indices 4..128 in order, one frame_done_out pulse.
REQ-037 bin_ready_in low throughout frame -> exactly 8 beats buffered, fft_ready_out low, no loss; release -> indices 4..128 delivered in order.
REQ-038 fft_last_in at index 500 -> state ALIGN, no frame_done_out; following aligned frame forwards normally.
REQ-039 Macro defined, mag_threshold 100, bin 10 mic0 RE -60 IM 30 -> bin 10 dropped, drop_count_out 1; bin 11 RE -32768 IM 0 -> forwarded.
REQ-040 rst_in asserted with 5 beats buffered -> next cycle bin_valid_out 0, FIFO empty; next frame's beats discarded until its last beat.
